// File: rtl/memory_writeback_cycle.sv
// Memory and write-back stages: EX/MEM register, data-memory req/ack access with a
// timeout, MEM/WB register, forwarding selects for execute and the pipeline stall.
module memory_writeback_cycle #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aluout,
  input  logic [15:0] bout,
  input  logic [3:0]  rdout,
  input  logic        regwriteout,
  input  logic [3:0]  opout,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        memtoreg,
  input  logic [3:0]  rs_a,
  input  logic [3:0]  rs_b,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic [15:0] new_mem_aluout,
  output logic [15:0] new_write_aluout,
  output logic [3:0]  wb_rd,
  output logic        wb_regwrite,
  output logic [3:0]  wb_op,
  output logic        stall,
  output logic        mem_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter runs 0..TIMEOUT-1 while in BUSY; the last value forces completion.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  // EX/MEM register
  logic [15:0] m_alu_q, m_b_q;
  logic [3:0]  m_rd_q, m_op_q;
  logic        m_regwrite_q, m_rd_en_q, m_wr_en_q, m_memtoreg_q;

  // MEM/WB register
  logic [15:0] wb_data_q;
  logic [3:0]  wb_rd_q, wb_op_q;
  logic        wb_regwrite_q;

  // Memory access FSM
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     load_data_q, load_data_d;
  logic            mem_err_q, mem_err_d;

  logic mem_busy, load_use;

  // Hazard detection: memory op not yet finished, or a load feeding the next instruction.
  always_comb begin
    mem_busy = ((state_q == IDLE) && (m_rd_en_q || m_wr_en_q)) || (state_q == BUSY);
    load_use = m_regwrite_q && m_rd_en_q && (m_rd_q != 4'd0) &&
               ((m_rd_q == rs_a) || (m_rd_q == rs_b));
    stall    = mem_busy || load_use;
  end

  // EX/MEM: hold during a memory access, insert a bubble on load-use, else capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_alu_q      <= '0;
      m_b_q        <= '0;
      m_rd_q       <= '0;
      m_op_q       <= '0;
      m_regwrite_q <= 1'b0;
      m_rd_en_q    <= 1'b0;
      m_wr_en_q    <= 1'b0;
      m_memtoreg_q <= 1'b0;
    end else if (!mem_busy) begin
      if (load_use) begin
        // Data fields are left as-is; cleared controls make the slot inert.
        m_regwrite_q <= 1'b0;
        m_rd_en_q    <= 1'b0;
        m_wr_en_q    <= 1'b0;
      end else begin
        m_alu_q      <= aluout;
        m_b_q        <= bout;
        m_rd_q       <= rdout;
        m_op_q       <= opout;
        m_regwrite_q <= regwriteout;
        m_rd_en_q    <= memread;
        m_wr_en_q    <= memwrite;
        m_memtoreg_q <= memtoreg;
      end
    end
  end

  // FSM next state: ack wins over timeout when both land in the same BUSY cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    mem_err_d   = mem_err_q;
    case (state_q)
      IDLE: begin
        if (m_rd_en_q || m_wr_en_q) begin
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          load_data_d = mem_rdata;
          state_d     = DONE;
        end else if (cnt_q == CntMax) begin
          load_data_d = '0;
          mem_err_d   = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, timeout counter, captured load data and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      load_data_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // MEM/WB: bubble while the memory stage is busy, otherwise retire the EX/MEM slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_data_q     <= '0;
      wb_rd_q       <= '0;
      wb_op_q       <= '0;
      wb_regwrite_q <= 1'b0;
    end else if (mem_busy) begin
      wb_regwrite_q <= 1'b0;
    end else begin
      wb_data_q     <= m_memtoreg_q ? load_data_q : m_alu_q;
      wb_rd_q       <= m_rd_q;
      wb_op_q       <= m_op_q;
      wb_regwrite_q <= m_regwrite_q;
    end
  end

  // Forwarding selects: memory stage first (never a pending load), then write-back.
  always_comb begin
    forward_a = 2'd0;
    if (m_regwrite_q && !m_rd_en_q && (rs_a != 4'd0) && (m_rd_q == rs_a)) begin
      forward_a = 2'd2;
    end else if (wb_regwrite_q && (rs_a != 4'd0) && (wb_rd_q == rs_a)) begin
      forward_a = 2'd1;
    end
    forward_b = 2'd0;
    if (m_regwrite_q && !m_rd_en_q && (rs_b != 4'd0) && (m_rd_q == rs_b)) begin
      forward_b = 2'd2;
    end else if (wb_regwrite_q && (rs_b != 4'd0) && (wb_rd_q == rs_b)) begin
      forward_b = 2'd1;
    end
  end

  // Memory bus driven only while the request is outstanding.
  always_comb begin
    mem_req   = (state_q == BUSY);
    mem_we    = mem_req && m_wr_en_q;
    mem_addr  = mem_req ? m_alu_q : 16'h0000;
    mem_wdata = mem_req ? m_b_q : 16'h0000;
  end

  assign new_mem_aluout   = m_alu_q;
  assign new_write_aluout = wb_data_q;
  assign wb_rd            = wb_rd_q;
  assign wb_regwrite      = wb_regwrite_q;
  assign wb_op            = wb_op_q;
  assign mem_err          = mem_err_q;

endmodule
